// File: rtl/regfile_pkg.sv
// Shared defaults and the writeback-op record for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef struct packed {
    logic                 en;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } regfile_op_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, reservation
// acceptance, writeback clears and a flush that drops every reservation.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int R0_ZERO = 1,
  localparam int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              flush,
  output logic              rsv_ok,
  output logic [NREG-1:0]   busy_o
);

  localparam logic HARD_R0 = (R0_ZERO != 0);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // A register being written back this cycle can be re-reserved at once.
  assign rsv_ok = !busy_q[rsv_addr] || (write_en && (write_addr == rsv_addr));
  assign busy_o = busy_q;

  // Next busy state: flush beats everything, otherwise a new reservation beats the clear.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      if (write_en) begin
        busy_d[write_addr] = 1'b0;
      end else begin
        busy_d = busy_d;
      end
      if (rsv_en && rsv_ok) begin
        busy_d[rsv_addr] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
    if (HARD_R0) begin
      busy_d[0] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Busy-bit register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= {NREG{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read / one-write register file with a destination scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic              a_busy,
  output logic              b_busy,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              flush
);

  localparam int   NREG    = 2 ** ADDR_W;
  localparam logic HARD_R0 = (R0_ZERO != 0);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_s;
  logic              wr_zero_s;
  logic              a_zero_s;
  logic              b_zero_s;

  assign wr_zero_s = HARD_R0 && (write_addr == {ADDR_W{1'b0}});
  assign a_zero_s  = HARD_R0 && (a_addr == {ADDR_W{1'b0}});
  assign b_zero_s  = HARD_R0 && (b_addr == {ADDR_W{1'b0}});

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .write_en   (write_en),
    .write_addr (write_addr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .rsv_ok     (rsv_ok),
    .busy_o     (busy_s)
  );

  // Data array; writes land regardless of busy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (write_en && !wr_zero_s) begin
      regs_q[write_addr] <= write_data;
    end else begin
      regs_q <= regs_q;
    end
  end

  // Read muxing for both ports, with optional same-cycle writeback forwarding.
  always_comb begin
    a_data = a_zero_s ? {DATA_W{1'b0}} : regs_q[a_addr];
    b_data = b_zero_s ? {DATA_W{1'b0}} : regs_q[b_addr];
    a_busy = busy_s[a_addr];
    b_busy = busy_s[b_addr];
`ifdef REGFILE_SB_BYPASS_EN
    if (write_en && (write_addr == a_addr) && !a_zero_s) begin
      a_data = write_data;
      a_busy = 1'b0;
    end else begin
      a_data = a_data;
    end
    if (write_en && (write_addr == b_addr) && !b_zero_s) begin
      b_data = write_data;
      b_busy = 1'b0;
    end else begin
      b_data = b_data;
    end
`else
    a_data = a_data;
    b_data = b_data;
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters).
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_busy, b_busy;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic        flush;

  int checks;
  int failures;

  regfile_sb dut (
    .clk        (clk),
    .rst        (rst),
    .a_addr     (a_addr),
    .b_addr     (b_addr),
    .a_data     (a_data),
    .b_data     (b_data),
    .a_busy     (a_busy),
    .b_busy     (b_busy),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .rsv_ok     (rsv_ok),
    .flush      (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then release one-shot controls.
  task automatic tick();
    @(posedge clk);
    #1;
    write_en = 1'b0;
    rsv_en   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drive_write(input regfile_op_t op);
    write_en   = op.en;
    write_addr = op.addr;
    write_data = op.data;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; a_addr = 5'd0; b_addr = 5'd1;
    write_en = 1'b0; write_addr = 5'd0; write_data = 32'h0;
    rsv_en = 1'b0; rsv_addr = 5'd0; flush = 1'b0;

    // Reset state
    for (int i = 0; i < 32; i += 4) begin
      a_addr = 5'(i); b_addr = 5'(i + 3);
      #1;
      chk("rst_a_data", a_data, 32'h0);
      chk("rst_b_data", b_data, 32'h0);
      chk("rst_busy", {30'h0, a_busy, b_busy}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Write r5, read next cycle
    drive_write('{en: 1'b1, addr: 5'd5, data: 32'hDEADBEEF});
    tick();
    a_addr = 5'd5; b_addr = 5'd5; #1;
    chk("wr5_a", a_data, 32'hDEADBEEF);
    chk("wr5_b", b_data, 32'hDEADBEEF);

    // Reserve r7, second reservation refused, writeback clears
    rsv_en = 1'b1; rsv_addr = 5'd7; a_addr = 5'd7; #1;
    chk("rsv7_ok", 32'(rsv_ok), 32'h1);
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd7; #1;
    chk("rsv7_busy", 32'(a_busy), 32'h1);
    chk("rsv7_again_ok", 32'(rsv_ok), 32'h0);
    tick();
    chk("rsv7_busy_hold", 32'(a_busy), 32'h1);
    drive_write('{en: 1'b1, addr: 5'd7, data: 32'h11}); #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("wr7_busy_same", 32'(a_busy), 32'h0);
`else
    chk("wr7_busy_same", 32'(a_busy), 32'h1);
`endif
    tick();
    chk("wr7_busy_next", 32'(a_busy), 32'h0);
    chk("wr7_data", a_data, 32'h11);

    // Same-cycle reservation and write to a busy r9
    rsv_en = 1'b1; rsv_addr = 5'd9; tick();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    drive_write('{en: 1'b1, addr: 5'd9, data: 32'h22}); #1;
    chk("rsv9_wr_ok", 32'(rsv_ok), 32'h1);
    tick();
    a_addr = 5'd9; #1;
    chk("rsv9_busy", 32'(a_busy), 32'h1);
    chk("rsv9_data", a_data, 32'h22);

    // Write while reading the same address
    a_addr = 5'd3; #1;
    chk("r3_before", a_data, 32'h0);
    drive_write('{en: 1'b1, addr: 5'd3, data: 32'h33}); #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("r3_same", a_data, 32'h33);
`else
    chk("r3_same", a_data, 32'h0);
`endif
    tick();
    chk("r3_next", a_data, 32'h33);

    // Reservations then flush (with a write and reservation in the flush cycle)
    drive_write('{en: 1'b1, addr: 5'd2, data: 32'h202}); tick();
    rsv_en = 1'b1; rsv_addr = 5'd1; tick();
    rsv_en = 1'b1; rsv_addr = 5'd2; tick();
    rsv_en = 1'b1; rsv_addr = 5'd4; tick();
    a_addr = 5'd1; b_addr = 5'd4; #1;
    chk("pre_flush_busy", {30'h0, a_busy, b_busy}, 32'h3);
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd8;
    drive_write('{en: 1'b1, addr: 5'd4, data: 32'h44});
    tick();
    chk("flush_busy14", {30'h0, a_busy, b_busy}, 32'h0);
    chk("flush_data4", b_data, 32'h44);
    a_addr = 5'd2; b_addr = 5'd8; #1;
    chk("flush_busy28", {30'h0, a_busy, b_busy}, 32'h0);
    chk("flush_data2", a_data, 32'h202);
    b_addr = 5'd9; #1;
    chk("flush_busy9", 32'(b_busy), 32'h0);

    // Hard-zero r0
    drive_write('{en: 1'b1, addr: 5'd0, data: 32'hFF}); tick();
    a_addr = 5'd0; #1;
    chk("r0_read", a_data, 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd0; #1;
    chk("r0_rsv_ok", 32'(rsv_ok), 32'h1);
    tick();
    chk("r0_busy", 32'(a_busy), 32'h0);

    // Asynchronous reset between edges
    drive_write('{en: 1'b1, addr: 5'd10, data: 32'h1010}); tick();
    rsv_en = 1'b1; rsv_addr = 5'd6; tick();
    a_addr = 5'd6; b_addr = 5'd10; #1;
    chk("pre_rst_busy6", 32'(a_busy), 32'h1);
    chk("pre_rst_r10", b_data, 32'h1010);
    rst = 1'b1; #1;
    chk("async_busy6", 32'(a_busy), 32'h0);
    chk("async_r10", b_data, 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd11;
    drive_write('{en: 1'b1, addr: 5'd12, data: 32'h1212});
    tick();
    a_addr = 5'd11; b_addr = 5'd12; #1;
    chk("rst_edge_busy11", 32'(a_busy), 32'h0);
    chk("rst_edge_r12", b_data, 32'h0);

    // First edge after reset release is accepted
    @(negedge clk);
    rst = 1'b0;
    drive_write('{en: 1'b1, addr: 5'd13, data: 32'h1313});
    rsv_en = 1'b1; rsv_addr = 5'd14;
    tick();
    a_addr = 5'd13; b_addr = 5'd14; #1;
    chk("post_rst_r13", a_data, 32'h1313);
    chk("post_rst_busy14", 32'(b_busy), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
